// File: rtl/out_fm_tile_store_sched.sv
// rtl/out_fm_tile_store_sched.sv - tile-level write-back scheduler for output feature maps
//
// Walks every output tile of a layer in compute order (column innermost, then
// row, then n). For each tile it drives the store engine through a
// store_start/store_done handshake while presenting the tile base coordinates.
// Finished-but-unstored tiles reported by the compute array are tracked in a
// credit counter. When that counter is full, compute is back-pressured.
//
// Optional feature macro: OUT_FM_SCHED_PERF_EN (WAIT_DONE cycle counter).
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   layer_start        pulse: begin a layer (ignored and flagged while busy)
//   layer_done         pulse: last tile has been stored
//   busy               high whenever the scheduler is not idle
//   tile_ready         pulse: compute finished one output tile
//   ready_full         credit counter is at MAX_READY
//   store_start        pulse: store engine should write the current tile
//   store_done         store engine finished the current tile
//   tile_base_n/row/col base coordinates of the current tile
//   sched_err          sticky protocol error, cleared by layer_start
//   store_wait_cycles  cycles spent waiting on the store engine (0 unless perf build)

module out_fm_tile_store_sched #(
    parameter int CW        = 16,
    parameter int M         = 32,
    parameter int R         = 64,
    parameter int C         = 32,
    parameter int Tm        = 16,
    parameter int Tr        = 64,
    parameter int Tc        = 16,
    parameter int MAX_READY = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          layer_start,
    output logic          layer_done,
    output logic          busy,
    input  logic          tile_ready,
    output logic          ready_full,
    output logic          store_start,
    input  logic          store_done,
    output logic [CW-1:0] tile_base_n,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic          sched_err,
    output logic [31:0]   store_wait_cycles
);

    localparam int CRW = $clog2(MAX_READY + 1);
    localparam int SW  = CW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_READY,
        S_ISSUE,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CRW-1:0] credit;
    logic [CW-1:0]  base_n;
    logic [CW-1:0]  base_row;
    logic [CW-1:0]  base_col;
    logic           err_flag;

    logic           start_layer;
    logic           credit_inc;
    logic           credit_dec;
    logic           err_set;

    // Coordinate advance, one bit wider than the bases so a sum near 2^CW
    // compares correctly instead of wrapping to a small value.
    logic [SW-1:0]  col_sum;
    logic [SW-1:0]  row_sum;
    logic [SW-1:0]  n_sum;
    logic           col_wrap;
    logic           row_wrap;
    logic           last_tile;
    logic [CW-1:0]  col_nx;
    logic [CW-1:0]  row_nx;
    logic [CW-1:0]  n_nx;

    // Outputs decoded from registered state only.
    assign busy        = (state != S_IDLE);
    assign store_start = (state == S_ISSUE);
    assign layer_done  = (state == S_FINISH);
    assign ready_full  = (credit == CRW'(MAX_READY));

    assign tile_base_n   = base_n;
    assign tile_base_row = base_row;
    assign tile_base_col = base_col;
    assign sched_err     = err_flag;

    // A layer only starts from idle; a start while busy is a protocol error.
    assign start_layer = (state == S_IDLE) && layer_start;

    // tile_ready is ignored while idle and dropped when the counter is full.
    assign credit_inc = tile_ready && busy && !ready_full;
    assign credit_dec = (state == S_ISSUE);

    assign err_set = (tile_ready && busy && ready_full)
                   || (store_done && (state != S_WAIT_DONE))
                   || (layer_start && busy);

    always_comb begin
        col_sum   = {1'b0, base_col} + SW'(Tc);
        row_sum   = {1'b0, base_row} + SW'(Tr);
        n_sum     = {1'b0, base_n} + SW'(Tm);
        col_wrap  = (col_sum >= SW'(C));
        row_wrap  = col_wrap && (row_sum >= SW'(R));
        last_tile = row_wrap && (n_sum >= SW'(M));

        col_nx = col_sum[CW-1:0];
        row_nx = base_row;
        n_nx   = base_n;
        if (col_wrap) begin
            col_nx = '0;
            row_nx = row_sum[CW-1:0];
            if (row_wrap) begin
                row_nx = '0;
                n_nx   = n_sum[CW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (layer_start) begin
                    state_nx = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (credit != '0) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (store_done) begin
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                state_nx = last_tile ? S_FINISH : S_WAIT_READY;
            end
            S_FINISH: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Simultaneous increment and decrement cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
        end else if (start_layer) begin
            credit <= '0;
        end else if (credit_inc && !credit_dec) begin
            credit <= credit + CRW'(1);
        end else if (credit_dec && !credit_inc) begin
            credit <= credit - CRW'(1);
        end
    end

    // Bases hold from ISSUE through WAIT_DONE and only move in NEXT. On the
    // last tile they stay put so the final coordinates remain visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_n   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if (start_layer) begin
            base_n   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if ((state == S_NEXT) && !last_tile) begin
            base_n   <= n_nx;
            base_row <= row_nx;
            base_col <= col_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (start_layer) begin
            err_flag <= 1'b0;
        end else if (err_set) begin
            err_flag <= 1'b1;
        end
    end

`ifdef OUT_FM_SCHED_PERF_EN
    logic [31:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (start_layer) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT_DONE) && (wait_cnt != 32'hFFFF_FFFF)) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign store_wait_cycles = wait_cnt;
`else
    assign store_wait_cycles = '0;
`endif

endmodule
